imem_loader: RTL
================

# imem_loader

Byte-stream program loader that writes a RISC-V program image into the pipelined core's instruction memory over a port-level write interface. It takes the place of the simulation-only `$readmemh` preload. It accepts a length-prefixed little-endian byte stream on a valid/ready handshake, assembles 32-bit instruction words, and writes them to consecutive word addresses. It holds the core in reset until the image is committed.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width; capacity `MAX_WORDS = 2**ADDR_W`.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `load_req` input 1: one-cycle pulse that restarts a load from any state.
- `in_valid` input 1: source has a byte on `in_data`.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `im_we` output 1: one-cycle instruction-memory write strobe.
- `im_addr` output ADDR_W: word address for the write.
- `im_wdata` output 32: instruction word for the write.
- `core_hold` output 1: reset request to the core; 1 means the core is held.
- `done` output 1: image fully written and accepted.
- `err` output 1: load aborted.

## Operation
- Stream format: 4-byte word count N (little-endian), then N×4 instruction bytes (little-endian per word). Optionally followed by a checksum byte (see Configuration).
- Byte transfer occurs on a rising edge with `in_valid && in_ready`. `in_ready = (state ∈ {HDR, DATA, CSUM}) && !load_req`, which is combinational.
- FSM states: HDR, DATA, CSUM, DONE, ERR.
  - Reset → HDR, with byte index 0, word index 0, and count 0.
  - HDR: shift the 4 bytes into `count[31:0]`. On the 4th byte:
    - count = 0 → DONE.
    - count > MAX_WORDS → ERR.
    - Otherwise → DATA.
  - DATA: shift bytes into the word register.
    - On the 4th byte of a word, register `im_we=1`, `im_addr=word index`, and `im_wdata=assembled word`, then increment the word index.
    - After the Nth word → CSUM if the checksum feature is compiled in, else DONE.
  - CSUM: compare the received byte with the running checksum. Match → DONE; mismatch → ERR.
  - DONE and ERR: terminal states; `in_ready=0`. Only `load_req` or `rst` leaves them.
- `load_req` in any state:
  - Clears the indices, count, checksum, `done`, `err`, and the partial word, and enters HDR.
  - Sets `core_hold=1`.
  - A byte presented in the same cycle is not accepted, because `in_ready` is 0.
  - Words already written are not erased.
- Addresses wrap never: the count check guarantees the word index stays below MAX_WORDS.
- `count` is compared at 32-bit width, so no truncation is possible.

## Timing
- Reset values: `in_ready`=0 while `rst` is low, `im_we`=0, `im_addr`=0, `im_wdata`=0, `core_hold`=1, `done`=0, `err`=0.
- Write latency: `im_we`/`im_addr`/`im_wdata` are valid in the cycle after the edge accepting the word's 4th byte. `im_we` is high for exactly that one cycle.
- Full throughput: one byte per cycle, i.e. one write every 4 cycles when `in_valid` stays high. Bubbles on `in_valid` only stretch timing.
- On entry to DONE, `done` is visible in the same cycle as the final `im_we` (no checksum) or the cycle after the CSUM byte (checksum).
- `core_hold` falls one cycle after `done` rises, so the last write is committed before the core leaves reset.
- On entry to ERR, `err` rises on the deciding edge, and `core_hold` stays 1.
- Asserting `rst` mid-load returns all outputs to their reset values immediately (asynchronously) and discards the partial word.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The checksum is the XOR of all N×4 data bytes (header excluded). The running checksum is cleared on reset and on `load_req`.
  - After the last word, the FSM enters CSUM and expects exactly one more byte.
  - A mismatch → ERR.
- Undefined:
  - CSUM is unreachable and the checksum register is absent.
  - DATA goes directly to DONE after the Nth word.
  - `err` is raised only by count overflow.

## Test plan
- Reset, then stream `02 00 00 00 | 93 00 50 00 | 13 01 A0 00` with `in_valid` held high → `im_we` pulses with (addr 0, 0x00500093), then 4 cycles later (addr 1, 0x00A00113). `done`=1 with the second write; `core_hold`=0 one cycle later.
- Stream `00 00 00 00` → DONE after the 4th header byte, no `im_we` pulse, `err`=0.
- ADDR_W=8, stream count `01 01 00 00` (257) → `err`=1, `in_ready`=0, `core_hold`=1, no writes. A subsequent `load_req` clears `err`.
- Same image as the first test with `in_valid` toggled 1/0 every cycle → identical write addresses and data, each write following its 4th accepted byte by exactly one cycle.
- Two data bytes into a word, pulse `load_req` while `in_valid`=1 → that byte is not accepted. Then stream count 1 and bytes `93 00 50 00` → single write at addr 0 = 0x00500093.
- With `IMEM_LOADER_CHECKSUM_EN`: count 1, bytes `93 00 50 00`, checksum `C3` → `done`=1. With checksum `00` instead → `err`=1, `done`=0, `core_hold`=1, and the addr-0 write has still occurred.

Source files
------------

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write port bundle
//
// Ports of the bundle:
//   in_valid/in_data/in_ready : byte stream, transfer when in_valid && in_ready
//   im_we/im_addr/im_wdata    : one-cycle instruction-memory write strobe
// Modports: slave = loader side, master = stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - length-prefixed byte-stream loader into instruction memory
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   load_req   : one-cycle pulse, restarts a load from any state
//   bus        : imem_loader_if.slave (byte stream in, imem write out)
//   core_hold  : 1 holds the core in reset
//   done       : image fully written
//   err        : load aborted (count overflow or checksum mismatch)
// Build option: IMEM_LOADER_CHECKSUM_EN appends an XOR checksum byte after
// the data bytes.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_req,
  imem_loader_if.slave  bus,
  output logic          core_hold,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERR} state_t;

  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  state_t            state, state_nxt;
  logic [1:0]        byte_idx;
  // One extra bit so the index can reach MAX_WORDS after the final word.
  logic [ADDR_W:0]   word_idx;
  logic [31:0]       count;
  logic [23:0]       part;
  logic              im_we_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [31:0]       im_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic        accept;
  logic [31:0] count_nxt;
  logic [31:0] word_nxt;
  logic        last_word;

  assign bus.in_ready = rst && !load_req &&
                        (state == HDR || state == DATA || state == CSUM);
  assign accept       = bus.in_valid && bus.in_ready;
  // Little-endian: each new byte enters at the top and older bytes shift down.
  assign count_nxt    = {bus.in_data, count[31:8]};
  assign word_nxt     = {bus.in_data, part};
  assign last_word    = (32'(word_idx) + 32'd1) == count;

  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HDR;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load_req) begin
      state_nxt = HDR;
    end else if (accept) begin
      case (state)
        HDR: begin
          if (byte_idx == 2'd3) begin
            if (count_nxt == 32'd0)          state_nxt = DONE;
            else if (count_nxt > MAX_WORDS)  state_nxt = ERR;
            else                             state_nxt = DATA;
          end
        end
        DATA: begin
          if (byte_idx == 2'd3 && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = DONE;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          // The running checksum already covers every data byte.
          state_nxt = (bus.in_data == csum) ? DONE : ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx   <= '0;
      word_idx   <= '0;
      count      <= '0;
      part       <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      core_hold  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      im_we_q <= 1'b0;
      if (load_req) begin
        // Previously written words stay in memory; only loader state clears.
        byte_idx  <= '0;
        word_idx  <= '0;
        count     <= '0;
        part      <= '0;
        core_hold <= 1'b1;
        done      <= 1'b0;
        err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum      <= '0;
`endif
      end else begin
        // Release the core one cycle after done, so the last write lands first.
        if (done) core_hold <= 1'b0;
        done <= (state_nxt == DONE);
        err  <= (state_nxt == ERR);
        if (accept) begin
          case (state)
            HDR: begin
              count    <= count_nxt;
              byte_idx <= byte_idx + 2'd1;
            end
            DATA: begin
              byte_idx <= byte_idx + 2'd1;
              part     <= {bus.in_data, part[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
              csum     <= csum ^ bus.in_data;
`endif
              if (byte_idx == 2'd3) begin
                im_we_q    <= 1'b1;
                im_addr_q  <= word_idx[ADDR_W-1:0];
                im_wdata_q <= word_nxt;
                word_idx   <= word_idx + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
